// File: rtl/fp_sequential_subtractor_if.sv
// Handshake and operand/result bundle for the sequential floating-point subtractor.
// The master side issues start with operands; the slave side reports busy/done/result.
interface fp_sequential_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, x, y, input busy, done, result);
    modport slave  (input start, x, y, output busy, done, result);
endinterface

// File: rtl/fp_sequential_subtractor.sv
// Multi-cycle single-precision subtractor (x - y): one alignment shift and one
// normalization shift per cycle, truncating, with a start/busy/done handshake.
module fp_sequential_subtractor #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    fp_sequential_subtractor_if.slave bus
);
    localparam int W  = 1 + EXP_W + MANT_W;
    localparam int MW = MANT_W + 2;   // {carry, hidden, frac}
    localparam int XW = EXP_W + 1;    // one spare bit so exp+1 never wraps

    localparam logic [EXP_W-1:0] EXP_ONES   = '1;
    localparam logic [XW-1:0]    EXP_INF    = {1'b0, EXP_ONES};
    localparam logic [XW-1:0]    EXP_ONE    = XW'(1);
    localparam logic [XW-1:0]    FULL_SHIFT = XW'(MW);
    localparam logic [W-1:0]     QNAN       = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [XW-1:0]     exp_q, exp_d;
    logic [XW-1:0]     cnt_q, cnt_d;
    logic [MW-1:0]     mant_a_q, mant_a_d;
    logic [MW-1:0]     mant_b_q, mant_b_d;
    logic [W-1:0]      result_q, result_d;

    logic              x_sign, y_sign;
    logic [EXP_W-1:0]  x_exp, y_exp;
    logic [MANT_W-1:0] x_frac, y_frac;
    logic [XW-1:0]     x_eexp, y_eexp, exp_diff;
    logic [MW-1:0]     x_mant, y_mant;
    logic              x_nan, y_nan, x_inf, y_inf, x_larger;
    logic [MW-1:0]     sum;
    logic [W-1:0]      packed_res;

    // Operand decode; y's sign is flipped so the datapath only ever adds.
    always_comb begin
        x_sign   = bus.x[W-1];
        x_exp    = bus.x[W-2:MANT_W];
        x_frac   = bus.x[MANT_W-1:0];
        y_sign   = ~bus.y[W-1];
        y_exp    = bus.y[W-2:MANT_W];
        y_frac   = bus.y[MANT_W-1:0];
        x_eexp   = (x_exp == '0) ? EXP_ONE : {1'b0, x_exp};
        y_eexp   = (y_exp == '0) ? EXP_ONE : {1'b0, y_exp};
        x_mant   = {1'b0, (x_exp != '0), x_frac};
        y_mant   = {1'b0, (y_exp != '0), y_frac};
        x_nan    = (x_exp == EXP_ONES) && (x_frac != '0);
        y_nan    = (y_exp == EXP_ONES) && (y_frac != '0);
        x_inf    = (x_exp == EXP_ONES) && (x_frac == '0);
        y_inf    = (y_exp == EXP_ONES) && (y_frac == '0);
        x_larger = (x_eexp > y_eexp) || ((x_eexp == y_eexp) && (x_mant >= y_mant));
        exp_diff = x_larger ? (x_eexp - y_eexp) : (y_eexp - x_eexp);
    end

    // Operand A is always the larger magnitude, so subtraction never goes negative.
    always_comb begin
        sum = (sign_a_q == sign_b_q) ? (mant_a_q + mant_b_q) : (mant_a_q - mant_b_q);
        if (mant_a_q == '0)
            packed_res = '0;
        else if (!mant_a_q[MW-2])
            packed_res = {sign_a_q, {EXP_W{1'b0}}, mant_a_q[MANT_W-1:0]};
        else if (exp_q >= EXP_INF)
            packed_res = {sign_a_q, EXP_ONES, {MANT_W{1'b0}}};
        else
            packed_res = {sign_a_q, exp_q[EXP_W-1:0], mant_a_q[MANT_W-1:0]};
    end

    // NOTE: every next-state signal defaults to its register first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        mant_a_d = mant_a_q;
        mant_b_d = mant_b_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (x_nan || y_nan || (x_inf && y_inf && (x_sign != y_sign))) begin
                        result_d = QNAN;
                        state_d  = S_DONE;
                    end else if (x_inf) begin
                        result_d = bus.x;
                        state_d  = S_DONE;
                    end else if (y_inf) begin
                        result_d = {y_sign, bus.y[W-2:0]};
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_ALIGN;
                        cnt_d   = exp_diff;
                        if (x_larger) begin
                            sign_a_d = x_sign;
                            exp_d    = x_eexp;
                            mant_a_d = x_mant;
                            sign_b_d = y_sign;
                            mant_b_d = y_mant;
                        end else begin
                            sign_a_d = y_sign;
                            exp_d    = y_eexp;
                            mant_a_d = y_mant;
                            sign_b_d = x_sign;
                            mant_b_d = x_mant;
                        end
                    end
                end
            end

            S_ALIGN: begin
                if (cnt_q == '0) begin
                    state_d = S_ADD;
                end else if (cnt_q >= FULL_SHIFT) begin
                    mant_b_d = '0;
                    state_d  = S_ADD;
                end else begin
                    mant_b_d = mant_b_q >> 1;
                    cnt_d    = cnt_q - EXP_ONE;
                    if (cnt_q == EXP_ONE)
                        state_d = S_ADD;
                end
            end

            S_ADD: begin
                state_d = S_NORM;
                if (sum[MW-1]) begin
                    mant_a_d = sum >> 1;
                    exp_d    = exp_q + EXP_ONE;
                end else begin
                    mant_a_d = sum;
                end
            end

            S_NORM: begin
                if ((mant_a_q == '0) || mant_a_q[MW-2] || (exp_q == EXP_ONE)) begin
                    result_d = packed_res;
                    state_d  = S_DONE;
                end else begin
                    mant_a_d = mant_a_q << 1;
                    exp_d    = exp_q - EXP_ONE;
                end
            end

            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, and the reset
    // covers the whole datapath so an aborted operation leaves no stale values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            exp_q    <= '0;
            cnt_q    <= '0;
            mant_a_q <= '0;
            mant_b_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            mant_a_q <= mant_a_d;
            mant_b_q <= mant_b_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_fp_sequential_subtractor.sv
// Self-checking bench for fp_sequential_subtractor: directed cases, protocol
// scenarios, and randomized operands against a plain-arithmetic reference model.
module tb_fp_sequential_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    fp_sequential_subtractor_if bus ();

    fp_sequential_subtractor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: x + (-y) with truncating alignment, then the documented latency.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output int lat);
        bit sa, sb, sl, ss;
        int ea, eb, fa, fb, ma, mb, el, es, ml, ms, m, e, d, n, align;
        sa = a[31];
        sb = ~b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = int'(a[22:0]);
        fb = int'(b[22:0]);
        lat = 1;
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) r = 32'h7FC00000;
        else if (ea == 255 && eb == 255 && sa != sb)          r = 32'h7FC00000;
        else if (ea == 255)                                   r = a;
        else if (eb == 255)                                   r = {sb, b[30:0]};
        else begin
            ma = (ea == 0) ? fa : fa + (1 << 23);
            mb = (eb == 0) ? fb : fb + (1 << 23);
            if (ea == 0) ea = 1;
            if (eb == 0) eb = 1;
            if (ea > eb || (ea == eb && ma >= mb)) begin
                sl = sa; el = ea; ml = ma; ss = sb; es = eb; ms = mb;
            end else begin
                sl = sb; el = eb; ml = mb; ss = sa; es = ea; ms = ma;
            end
            d     = el - es;
            align = (d == 0 || d >= 25) ? 1 : d;
            ms    = (d >= 25) ? 0 : (ms >> d);
            m     = (sl == ss) ? ml + ms : ml - ms;
            e     = el;
            if (m >= (1 << 24)) begin
                m = m >> 1;
                e++;
            end
            n = 0;
            while (m != 0 && m < (1 << 23) && e > 1) begin
                m = m << 1;
                e--;
                n++;
            end
            if (m == 0)              r = 32'h0;
            else if (m < (1 << 23))  r = {sl, 8'h00, 23'(m)};
            else if (e >= 255)       r = {sl, 8'hFF, 23'h0};
            else                     r = {sl, 8'(e), 23'(m)};
            lat = align + n + 3;
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] specials [6];
        int k;
        specials = '{32'h00000000, 32'h80000000, 32'h7F800000,
                     32'hFF800000, 32'h7FC00000, 32'h7F800001};
        k = int'($urandom_range(0, 9));
        if (k == 0)      return $urandom;
        else if (k == 1) return specials[$urandom_range(0, 5)];
        else if (k == 2) return {1'($urandom), 8'h00, 23'($urandom)};
        else             return {1'($urandom), 8'(120 + $urandom_range(0, 12)), 23'($urandom)};
    endfunction

    // One operation: accept, optional stray start at cycle 'inject', bounded wait for done.
    task automatic run_op(input string tag, input logic [31:0] xa, input logic [31:0] ya,
                          input logic [31:0] exp_r, input int exp_lat, input int inject);
        int cyc;
        bit busy_ok;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = xa;
        bus.y     = ya;
        @(negedge clk);
        bus.start = 1'b0;
        bus.x     = $urandom;
        bus.y     = $urandom;
        cyc       = 1;
        busy_ok   = 1'b1;
        while (!bus.done && cyc < 400) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (cyc == inject) bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        check({tag, " done seen"}, 32'(bus.done), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, bus.result, exp_r);
        check({tag, " busy"}, 32'(busy_ok & bus.busy), 32'd1);
        @(negedge clk);
        check({tag, " idle after done"}, {30'd0, bus.busy, bus.done}, 32'd0);
        check({tag, " result held"}, bus.result, exp_r);
    endtask

    typedef struct {
        logic [31:0] xa;
        logic [31:0] ya;
        logic [31:0] r;
        int          lat;
    } vec_t;

    initial begin
        vec_t        dir [10];
        logic [31:0] xa, ya, er, pend_r, last_r;
        int          el, accept_t, done_t, ndone;

        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        repeat (3) @(negedge clk);
        check("reset busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("reset result", bus.result, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset idle", {30'd0, bus.busy, bus.done}, 32'd0);

        dir = '{
            '{32'h3FC00000, 32'h3F800000, 32'h3F000000, 5},
            '{32'h40000000, 32'hBF800000, 32'h40400000, 4},
            '{32'h3F800000, 32'h3F800000, 32'h00000000, 4},
            '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1},
            '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1},
            '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1},
            '{32'h3F800000, 32'hFF800000, 32'h7F800000, 1},
            '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4},
            '{32'h00800000, 32'h00400000, 32'h00400000, 4},
            '{32'h4B800000, 32'h3F800000, 32'h4B800000, 27}
        };
        foreach (dir[i])
            run_op($sformatf("dir%0d", i), dir[i].xa, dir[i].ya, dir[i].r, dir[i].lat, 0);

        run_op("start during align", 32'h4B800000, 32'h3F800000, 32'h4B800000, 27, 3);

        // Reset in the middle of a long normalization (23 shifts).
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = 32'h3F800001;
        bus.y     = 32'h3F800000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("in flight before reset", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid-norm reset busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("mid-norm reset result", bus.result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after reset", 32'h3FC00000, 32'h3F800000, 32'h3F000000, 5, 0);

        // Back-to-back: start held high, operands changing every cycle.
        last_r   = 32'h3F000000;
        accept_t = 0;
        done_t   = -1;
        ndone    = 0;
        for (int t = 0; t < 600 && ndone < 3; t++) begin
            @(negedge clk);
            if (t == done_t) begin
                check($sformatf("b2b done t%0d", t), 32'(bus.done), 32'd1);
                check($sformatf("b2b result t%0d", t), bus.result, pend_r);
                last_r = pend_r;
                ndone++;
            end else begin
                check($sformatf("b2b no done t%0d", t), 32'(bus.done), 32'd0);
                check($sformatf("b2b stable t%0d", t), bus.result, last_r);
            end
            xa = {1'($urandom), 8'(125 + $urandom_range(0, 4)), 23'($urandom)};
            ya = {1'($urandom), 8'(125 + $urandom_range(0, 4)), 23'($urandom)};
            bus.start = 1'b1;
            bus.x     = xa;
            bus.y     = ya;
            if (t == accept_t) begin
                ref_model(xa, ya, pend_r, el);
                done_t   = t + el;
                accept_t = done_t + 1;
            end
        end
        bus.start = 1'b0;
        check("b2b done count", 32'(ndone), 32'd3);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 120; i++) begin
            xa = rand_op();
            ya = ($urandom_range(0, 3) == 0) ? (xa ^ 32'($urandom_range(0, 15))) : rand_op();
            ref_model(xa, ya, er, el);
            run_op($sformatf("rand%0d %h-%h", i, xa, ya), xa, ya, er, el, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
